// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg -- shared widths, opcodes, state encoding and the
// single-cycle result function for the ALU execution unit.
// Build option: define ALU_MUL_EN to enable the iterative multiplier
// (MUL / MULHU); without it those opcodes behave as undefined ops.
package alu_exec_pkg;

  localparam int WORD_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int OP_W    = 6;
  localparam int REG_W   = 5;
  localparam int SHAMT_W = 5;

  // A tag is unlocked when every bit equals this value (all-ones).
  localparam logic UNLOCKED_BIT = 1'b1;

  localparam logic [OP_W-1:0] OP_ADD   = 6'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd1;
  localparam logic [OP_W-1:0] OP_SLL   = 6'd2;
  localparam logic [OP_W-1:0] OP_SLT   = 6'd3;
  localparam logic [OP_W-1:0] OP_SLTU  = 6'd4;
  localparam logic [OP_W-1:0] OP_XOR   = 6'd5;
  localparam logic [OP_W-1:0] OP_SRL   = 6'd6;
  localparam logic [OP_W-1:0] OP_SRA   = 6'd7;
  localparam logic [OP_W-1:0] OP_OR    = 6'd8;
  localparam logic [OP_W-1:0] OP_AND   = 6'd9;
  localparam logic [OP_W-1:0] OP_LUI   = 6'd10;
  localparam logic [OP_W-1:0] OP_AUIPC = 6'd11;
  localparam logic [OP_W-1:0] OP_MUL   = 6'd12;
  localparam logic [OP_W-1:0] OP_MULHU = 6'd13;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Ops that go through the multi-cycle multiplier.
  function automatic logic is_mul_op(input logic [OP_W-1:0] op);
    logic r;
    case (op)
      OP_MUL:   r = 1'b1;
      OP_MULHU: r = 1'b1;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DONE = 2'd2
  } alu_state_e;
`endif

  // Single-cycle result; anything not listed (including the multiply
  // opcodes, which the multiplier path handles) yields zero.
  function automatic logic [WORD_W-1:0] alu_calc(
    input logic [OP_W-1:0]   op,
    input logic [ADDR_W-1:0] pc,
    input logic [WORD_W-1:0] x,
    input logic [WORD_W-1:0] y
  );
    logic [SHAMT_W-1:0] sh;
    logic [WORD_W-1:0]  r;
    sh = y[SHAMT_W-1:0];
    r  = {WORD_W{1'b0}};
    case (op)
      OP_ADD:   r = x + y;
      OP_SUB:   r = x - y;
      OP_SLL:   r = x << sh;
      OP_SLT:   r = {{(WORD_W-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_SLTU:  r = {{(WORD_W-1){1'b0}}, (x < y)};
      OP_XOR:   r = x ^ y;
      OP_SRL:   r = x >> sh;
      OP_SRA:   r = $signed(x) >>> sh;
      OP_OR:    r = x | y;
      OP_AND:   r = x & y;
      OP_LUI:   r = y;
      OP_AUIPC: r = pc + y;
      default:  r = {WORD_W{1'b0}};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter -- iterative 32x32 shift-add multiplier, one partial
// product per enabled cycle, 32 steps. Present only when ALU_MUL_EN is
// defined. 'product' is the accumulator after the current step, so it
// holds the full 64-bit result in the cycle 'done' is high.
`ifdef ALU_MUL_EN
module alu_mul_iter
  import alu_exec_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clear,
  input  logic                start,
  input  logic [WORD_W-1:0]   a,
  input  logic [WORD_W-1:0]   b,
  output logic [2*WORD_W-1:0] product,
  output logic                done
);

  logic [2*WORD_W-1:0] acc_r;
  logic [2*WORD_W-1:0] mcand_r;
  logic [WORD_W-1:0]   mplier_r;
  logic [5:0]          cnt_r;
  logic                run_r;
  logic [2*WORD_W-1:0] acc_nx_s;

  // Add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_nx_s = acc_r;
    if (mplier_r[0]) begin
      acc_nx_s = acc_r + mcand_r;
    end else begin
      acc_nx_s = acc_r;
    end
  end

  assign product = acc_nx_s;
  assign done    = run_r && (cnt_r == 6'd31);

  // Load operands on start, then step once per enabled cycle until done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_r    <= {(2*WORD_W){1'b0}};
      mcand_r  <= {(2*WORD_W){1'b0}};
      mplier_r <= {WORD_W{1'b0}};
      cnt_r    <= 6'd0;
      run_r    <= 1'b0;
    end else if (en) begin
      if (clear) begin
        run_r <= 1'b0;
        cnt_r <= 6'd0;
      end else if (start) begin
        acc_r    <= {(2*WORD_W){1'b0}};
        mcand_r  <= {{WORD_W{1'b0}}, a};
        mplier_r <= b;
        cnt_r    <= 6'd0;
        run_r    <= 1'b1;
      end else if (run_r) begin
        acc_r    <= acc_nx_s;
        mcand_r  <= mcand_r << 1;
        mplier_r <= mplier_r >> 1;
        if (cnt_r == 6'd31) begin
          run_r <= 1'b0;
          cnt_r <= 6'd0;
        end else begin
          cnt_r <= cnt_r + 6'd1;
        end
      end
    end
  end

endmodule
`endif

// File: rtl/alu_exec.sv
// alu_exec -- integer execution unit fed by one reservation-station
// entry. Accepts the entry once both operand tags are unlocked, computes
// the result and presents it on the result bus until granted.
// Build option: ALU_MUL_EN adds the MUL state and the alu_mul_iter
// multiplier for MUL / MULHU.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              busy_in,
  input  logic [OP_W-1:0]   op_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [TAG_W-1:0]  tagx_in,
  input  logic [TAG_W-1:0]  tagy_in,
  input  logic [TAG_W-1:0]  tagw_in,
  input  logic [WORD_W-1:0] datax_in,
  input  logic [WORD_W-1:0] datay_in,
  input  logic [REG_W-1:0]  target_in,
  input  logic              flush,
  input  logic              cdb_gnt,
  output logic              busy_out,
  output logic              en_out,
  output logic [WORD_W-1:0] data_out,
  output logic [TAG_W-1:0]  tag_out,
  output logic [REG_W-1:0]  target_out
);

  localparam logic [TAG_W-1:0] TAG_UNLOCKED = {TAG_W{UNLOCKED_BIT}};

  alu_state_e        state_r;
  alu_state_e        state_nx_s;
  logic              ready_s;
  logic              accept_s;
  logic              busy_s;
  logic              en_r;
  logic [WORD_W-1:0] data_r;
  logic [TAG_W-1:0]  tag_r;
  logic [REG_W-1:0]  target_r;

  assign ready_s = busy_in && (tagx_in == TAG_UNLOCKED) && (tagy_in == TAG_UNLOCKED);

`ifdef ALU_MUL_EN
  logic [OP_W-1:0]     op_r;
  logic                mul_start_s;
  logic                mul_done_s;
  logic [2*WORD_W-1:0] mul_prod_s;

  assign mul_start_s = accept_s && is_mul_op(op_in);

  alu_mul_iter u_mul (
    .clk     (clk),
    .rst     (rst),
    .en      (rdy),
    .clear   (flush),
    .start   (mul_start_s),
    .a       (datax_in),
    .b       (datay_in),
    .product (mul_prod_s),
    .done    (mul_done_s)
  );
`endif

  // Next state and acceptance; flush squashes everything including a grant.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    if (flush) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ready_s) begin
            accept_s = 1'b1;
`ifdef ALU_MUL_EN
            state_nx_s = is_mul_op(op_in) ? ST_MUL : ST_DONE;
`else
            state_nx_s = ST_DONE;
`endif
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
`ifdef ALU_MUL_EN
        ST_MUL: begin
          if (mul_done_s) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_MUL;
          end
        end
`endif
        ST_DONE: begin
          if (cdb_gnt) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_DONE;
          end
        end
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // State and registered result; everything freezes while rdy is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      en_r     <= 1'b0;
      data_r   <= {WORD_W{1'b0}};
      tag_r    <= TAG_UNLOCKED;
      target_r <= {REG_W{1'b0}};
`ifdef ALU_MUL_EN
      op_r     <= OP_ADD;
`endif
    end else if (rdy) begin
      state_r <= state_nx_s;
      en_r    <= (state_nx_s == ST_DONE);
      if (accept_s) begin
        tag_r    <= tagw_in;
        target_r <= target_in;
`ifdef ALU_MUL_EN
        op_r     <= op_in;
        if (!is_mul_op(op_in)) begin
          data_r <= alu_calc(op_in, pc_in, datax_in, datay_in);
        end
`else
        data_r   <= alu_calc(op_in, pc_in, datax_in, datay_in);
`endif
      end
`ifdef ALU_MUL_EN
      if ((state_r == ST_MUL) && !flush && mul_done_s) begin
        data_r <= (op_r == OP_MULHU) ? mul_prod_s[2*WORD_W-1:WORD_W]
                                     : mul_prod_s[WORD_W-1:0];
      end
`endif
    end
  end

  // Occupancy seen by the station: follows the entry when idle, held
  // while multiplying, released in the cycle the result is granted.
  always_comb begin
    busy_s = busy_in;
    case (state_r)
      ST_IDLE: busy_s = busy_in;
`ifdef ALU_MUL_EN
      ST_MUL:  busy_s = 1'b1;
`endif
      ST_DONE: busy_s = !cdb_gnt;
      default: busy_s = busy_in;
    endcase
  end

  assign busy_out   = busy_s;
  assign en_out     = en_r;
  assign data_out   = data_r;
  assign tag_out    = tag_r;
  assign target_out = target_r;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec -- directed bench for alu_exec with a behavioural
// reference checked every cycle plus literal expectations per vector.
// Honours ALU_MUL_EN the same way the design does.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        busy_in = 1'b0;
  logic [5:0]  op_in = 6'd0;
  logic [31:0] pc_in = 32'd0;
  logic [3:0]  tagx_in = 4'hF;
  logic [3:0]  tagy_in = 4'hF;
  logic [3:0]  tagw_in = 4'd0;
  logic [31:0] datax_in = 32'd0;
  logic [31:0] datay_in = 32'd0;
  logic [4:0]  target_in = 5'd0;
  logic        flush = 1'b0;
  logic        cdb_gnt = 1'b0;
  logic        busy_out;
  logic        en_out;
  logic [31:0] data_out;
  logic [3:0]  tag_out;
  logic [4:0]  target_out;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  alu_exec #(.TAG_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .busy_in(busy_in), .op_in(op_in),
    .pc_in(pc_in), .tagx_in(tagx_in), .tagy_in(tagy_in), .tagw_in(tagw_in),
    .datax_in(datax_in), .datay_in(datay_in), .target_in(target_in),
    .flush(flush), .cdb_gnt(cdb_gnt), .busy_out(busy_out), .en_out(en_out),
    .data_out(data_out), .tag_out(tag_out), .target_out(target_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference result from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] pc,
                                          input logic [31:0] x, input logic [31:0] y);
    logic [63:0] ux, uy, p, pw;
    int sh;
    ux = {32'd0, x};
    uy = {32'd0, y};
    sh = int'(y & 32'd31);
    pw = 64'd1 << sh;
    case (op)
      0:  p = ux + uy;
      1:  p = (64'h1_0000_0000 + ux) - uy;
      2:  p = ux * pw;
      3:  p = (int'(x) < int'(y)) ? 64'd1 : 64'd0;
      4:  p = (ux < uy) ? 64'd1 : 64'd0;
      5:  p = ux ^ uy;
      6:  p = ux / pw;
      7:  p = x[31] ? ~({32'd0, ~x} / pw) : (ux / pw);
      8:  p = ux | uy;
      9:  p = ux & uy;
      10: p = uy;
      11: p = {32'd0, pc} + uy;
`ifdef ALU_MUL_EN
      12: p = ux * uy;
      13: p = (ux * uy) >> 32;
`endif
      default: p = 64'd0;
    endcase
    return p[31:0];
  endfunction

  function automatic int ref_wait(input int op);
`ifdef ALU_MUL_EN
    if (op == 12 || op == 13) return 32;
`endif
    return 0;
  endfunction

  // Behavioural model: is a result pending, how long until it shows.
  bit          m_occ = 1'b0;
  int          m_remain = 0;
  logic [31:0] m_data = 32'd0;
  logic [3:0]  m_tag = 4'hF;
  logic [4:0]  m_target = 5'd0;

  always @(posedge clk) begin
    if (!rst) begin
      m_occ = 1'b0; m_remain = 0; m_data = 32'd0; m_tag = 4'hF; m_target = 5'd0;
    end else if (rdy) begin
      if (flush) begin
        m_occ = 1'b0;
      end else if (!m_occ) begin
        if (busy_in && tagx_in == 4'hF && tagy_in == 4'hF) begin
          m_occ = 1'b1;
          m_remain = ref_wait(int'(op_in));
          m_data = ref_alu(int'(op_in), pc_in, datax_in, datay_in);
          m_tag = tagw_in;
          m_target = target_in;
        end
      end else if (m_remain > 0) begin
        m_remain--;
      end else if (cdb_gnt) begin
        m_occ = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      logic exp_en, exp_busy;
      exp_en = m_occ && (m_remain == 0);
      if (!m_occ) exp_busy = busy_in;
      else if (m_remain > 0) exp_busy = 1'b1;
      else exp_busy = !cdb_gnt;
      chk("mdl en_out", {31'd0, en_out}, {31'd0, exp_en});
      chk("mdl busy_out", {31'd0, busy_out}, {31'd0, exp_busy});
      if (exp_en) begin
        chk("mdl data_out", data_out, m_data);
        chk("mdl tag_out", {28'd0, tag_out}, {28'd0, m_tag});
        chk("mdl target_out", {27'd0, target_out}, {27'd0, m_target});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] x,
                       input logic [31:0] y, input logic [3:0] tw, input logic [4:0] tg);
    busy_in = 1'b1; op_in = op; pc_in = pc; datax_in = x; datay_in = y;
    tagx_in = 4'hF; tagy_in = 4'hF; tagw_in = tw; target_in = tg;
  endtask

  task automatic run_op(input string nm, input logic [5:0] op, input logic [31:0] pc,
                        input logic [31:0] x, input logic [31:0] y, input logic [3:0] tw,
                        input logic [4:0] tg, input logic [31:0] exp, input int lat,
                        input int hold);
    int n;
    drive(op, pc, x, y, tw, tg);
    step();
    busy_in = 1'b0;
    n = 0;
    while (en_out !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk({nm, " en"}, {31'd0, en_out}, 32'd1);
    chk({nm, " latency"}, n, lat);
    chk({nm, " data"}, data_out, exp);
    chk({nm, " tag"}, {28'd0, tag_out}, {28'd0, tw});
    chk({nm, " target"}, {27'd0, target_out}, {27'd0, tg});
    for (int i = 0; i < hold; i++) begin
      step();
      chk({nm, " hold en"}, {31'd0, en_out}, 32'd1);
      chk({nm, " hold data"}, data_out, exp);
    end
    cdb_gnt = 1'b1;
    #1;
    chk({nm, " busy at grant"}, {31'd0, busy_out}, 32'd0);
    step();
    cdb_gnt = 1'b0;
    chk({nm, " en after grant"}, {31'd0, en_out}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mul_lo, mul_hi;
    int          mul_lat;
`ifdef ALU_MUL_EN
    mul_lo = 32'h0000002A; mul_hi = 32'hFFFFFFFE; mul_lat = 32;
`else
    mul_lo = 32'h00000000; mul_hi = 32'h00000000; mul_lat = 0;
`endif
    // Reset
    step(); step();
    rst = 1'b1;
    check_en = 1'b1;
    chk("reset en_out", {31'd0, en_out}, 32'd0);
    chk("reset data_out", data_out, 32'd0);
    chk("reset target_out", {27'd0, target_out}, 32'd0);
    chk("reset tag_out", {28'd0, tag_out}, 32'h0000000F);
    busy_in = 1'b1; tagx_in = 4'h0;
    #1;
    chk("reset busy follows busy_in", {31'd0, busy_out}, 32'd1);
    busy_in = 1'b0; tagx_in = 4'hF;
    step();

    // Single-cycle ops, hand-computed results
    run_op("ADD wrap", 6'd0, 32'd0, 32'hFFFFFFFF, 32'd2, 4'd5, 5'd7, 32'h00000001, 0, 0);
    run_op("SUB", 6'd1, 32'd0, 32'd0, 32'd1, 4'd1, 5'd1, 32'hFFFFFFFF, 0, 0);
    run_op("SLL", 6'd2, 32'd0, 32'd1, 32'h21, 4'd2, 5'd2, 32'h00000002, 0, 0);
    run_op("SLT", 6'd3, 32'd0, 32'hFFFFFFFF, 32'd1, 4'd3, 5'd3, 32'h00000001, 0, 0);
    run_op("SLTU", 6'd4, 32'd0, 32'd1, 32'hFFFFFFFF, 4'd4, 5'd4, 32'h00000001, 0, 0);
    run_op("XOR", 6'd5, 32'd0, 32'hF0F0F0F0, 32'hFFFF0000, 4'd6, 5'd5, 32'h0F0FF0F0, 0, 0);
    run_op("SRL", 6'd6, 32'd0, 32'h80000000, 32'h1F, 4'd7, 5'd6, 32'h00000001, 0, 0);
    run_op("SRA", 6'd7, 32'd0, 32'h80000000, 32'h24, 4'd8, 5'd8, 32'hF8000000, 0, 0);
    run_op("OR", 6'd8, 32'd0, 32'h12340000, 32'h00005678, 4'd9, 5'd9, 32'h12345678, 0, 0);
    run_op("AND", 6'd9, 32'd0, 32'hFF00FF00, 32'h0F0F0F0F, 4'd10, 5'd10, 32'h0F000F00, 0, 0);
    run_op("LUI", 6'd10, 32'd0, 32'h11111111, 32'hABCDE000, 4'd11, 5'd11, 32'hABCDE000, 0, 0);
    run_op("AUIPC", 6'd11, 32'h00001000, 32'd0, 32'hFFFFF000, 4'd12, 5'd12, 32'h00000000, 0, 0);
    run_op("undef op", 6'd63, 32'd0, 32'd5, 32'd6, 4'd13, 5'd13, 32'h00000000, 0, 0);
    run_op("MUL", 6'd12, 32'd0, 32'd7, 32'd6, 4'd1, 5'd14, mul_lo, mul_lat, 0);
    run_op("MULHU", 6'd13, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2, 5'd15, mul_hi, mul_lat, 0);

    // Grant withheld 4 cycles
    run_op("gnt hold", 6'd0, 32'd0, 32'd100, 32'd23, 4'd3, 5'd16, 32'd123, 0, 4);

    // Locked operand tag for 3 cycles
    drive(6'd0, 32'd0, 32'd5, 32'd6, 4'd2, 5'd3);
    tagy_in = 4'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("locked busy", {31'd0, busy_out}, 32'd1);
      step();
      chk("locked en", {31'd0, en_out}, 32'd0);
    end
    tagy_in = 4'hF;
    step();
    busy_in = 1'b0;
    chk("unlock en", {31'd0, en_out}, 32'd1);
    chk("unlock data", data_out, 32'd11);
    cdb_gnt = 1'b1; step(); cdb_gnt = 1'b0;

    // Flush beats a simultaneous grant in DONE
    drive(6'd0, 32'd0, 32'd1, 32'd1, 4'd4, 5'd4);
    step();
    busy_in = 1'b0;
    flush = 1'b1; cdb_gnt = 1'b1;
    step();
    flush = 1'b0; cdb_gnt = 1'b0;
    chk("flush in DONE en", {31'd0, en_out}, 32'd0);

    // Flush beats acceptance
    drive(6'd0, 32'd0, 32'd1, 32'd1, 4'd4, 5'd4);
    flush = 1'b1;
    step();
    flush = 1'b0; busy_in = 1'b0;
    chk("flush at accept en", {31'd0, en_out}, 32'd0);
    step();
    chk("flush at accept stays idle", {31'd0, en_out}, 32'd0);

    // rdy low freezes DONE and ignores flush/grant; also blocks acceptance
    drive(6'd1, 32'd0, 32'd10, 32'd3, 4'd5, 5'd9);
    rdy = 1'b0;
    step();
    chk("rdy low no accept", {31'd0, en_out}, 32'd0);
    rdy = 1'b1;
    step();
    busy_in = 1'b0;
    chk("rdy accept en", {31'd0, en_out}, 32'd1);
    rdy = 1'b0; flush = 1'b1; cdb_gnt = 1'b1;
    step(); step();
    chk("rdy low hold en", {31'd0, en_out}, 32'd1);
    chk("rdy low hold data", data_out, 32'd7);
    rdy = 1'b1; flush = 1'b0;
    step();
    cdb_gnt = 1'b0;
    chk("rdy release grant en", {31'd0, en_out}, 32'd0);

    // Reset in DONE with grant and rdy low: result discarded
    drive(6'd0, 32'd0, 32'd2, 32'd2, 4'd6, 5'd6);
    step();
    busy_in = 1'b0;
    rst = 1'b0; cdb_gnt = 1'b1; rdy = 1'b0;
    step();
    rst = 1'b1; cdb_gnt = 1'b0; rdy = 1'b1;
    chk("rst in DONE en", {31'd0, en_out}, 32'd0);
    chk("rst in DONE tag", {28'd0, tag_out}, 32'h0000000F);
    chk("rst in DONE data", data_out, 32'd0);

`ifdef ALU_MUL_EN
    // Flush partway through a multiply
    drive(6'd13, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd7, 5'd7);
    step();
    busy_in = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("mul busy mid", {31'd0, busy_out}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        if (en_out === 1'b1) seen++;
        step();
      end
      chk("mul flush no en", seen, 32'd0);
    end
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
